// File: rtl/etap_pkg.sv
// Shared EJTAG TAP constants: DR channel indices and default scan lengths.
// dr_len_default() builds the packed per-channel length table used by etap_dr_router.
package etap_pkg;

   localparam int unsigned CH_IDCODE         = 0;
   localparam int unsigned CH_IMPCODE        = 1;
   localparam int unsigned CH_ADDRESS        = 2;
   localparam int unsigned CH_DATA           = 3;
   localparam int unsigned CH_CONTROL        = 4;
   localparam int unsigned CH_EJTAGBOOT      = 5;
   localparam int unsigned CH_SAMPLE_PRELOAD = 6;
   localparam int unsigned CH_BYPASS         = 7;

   localparam int unsigned DEFAULT_DR_LEN = 32;
   localparam int unsigned BYPASS_DR_LEN  = 1;

   // Upper bound on the packed length table width (channels x counter width).
   localparam int unsigned DR_LEN_MAX_W = 256;

   // Every channel expects DEFAULT_DR_LEN bits except the bypass slot.
   function automatic logic [DR_LEN_MAX_W-1:0] dr_len_default(
      input int unsigned num_dr,
      input int unsigned cnt_w,
      input int unsigned bypass_ch
   );
      logic [DR_LEN_MAX_W-1:0] tbl;
      int unsigned             len;
      tbl = '0;
      for (int unsigned i = 0; i < num_dr; i++) begin
         len = (i == bypass_ch) ? BYPASS_DR_LEN : DEFAULT_DR_LEN;
         len = len & ((32'd1 << cnt_w) - 32'd1);
         tbl = tbl | (DR_LEN_MAX_W'(len) << (i * cnt_w));
      end
      return tbl;
   endfunction

endpackage

// File: rtl/etap_dr_router_if.sv
// DR routing bus between the TAP controller / IR decoder (master) and the router (slave).
interface etap_dr_router_if #(
   parameter int unsigned NUM_DR = 8,
   parameter int unsigned SEL_W  = 4,
   parameter int unsigned CNT_W  = 8
);

   logic              test_logic_reset;
   logic [SEL_W-1:0]  ir_sel;
   logic              update_ir;
   logic              capture_dr;
   logic              shift_dr;
   logic              update_dr;
   logic [NUM_DR-1:0] s_data_in;

   logic [NUM_DR-1:0] capture_en_out;
   logic [NUM_DR-1:0] shift_en_out;
   logic [NUM_DR-1:0] update_en_out;
   logic              s_data_out;
   logic              s_data_oe;
   logic [SEL_W-1:0]  sel_cur;
   logic [CNT_W-1:0]  scan_len;
   logic              len_err;

   modport master (
      output test_logic_reset, ir_sel, update_ir, capture_dr, shift_dr, update_dr, s_data_in,
      input  capture_en_out, shift_en_out, update_en_out, s_data_out, s_data_oe,
             sel_cur, scan_len, len_err
   );

   modport slave (
      input  test_logic_reset, ir_sel, update_ir, capture_dr, shift_dr, update_dr, s_data_in,
      output capture_en_out, shift_en_out, update_en_out, s_data_out, s_data_oe,
             sel_cur, scan_len, len_err
   );

endinterface

// File: rtl/etap_scan_counter.sv
// Per-scan shifted-bit counter with saturation and DR length check.
// Only instantiated when ETAP_DR_LEN_CHECK_EN is defined.
module etap_scan_counter #(
   parameter int unsigned             NUM_DR = 8,
   parameter int unsigned             SEL_W  = 4,
   parameter int unsigned             CNT_W  = 8,
   parameter logic [NUM_DR*CNT_W-1:0] DR_LEN = '0
) (
   input  logic             tck,
   input  logic             trst_n,
   input  logic             tlr_i,
   input  logic             capture_i,
   input  logic             shift_i,
   input  logic             update_i,
   input  logic [SEL_W-1:0] sel_i,
   output logic [CNT_W-1:0] scan_len_o,
   output logic             len_err_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             len_err_q, len_err_d;
   logic [CNT_W-1:0] exp_len_c;

   // Expected length of the active channel.
   always_comb begin
      exp_len_c = '0;
      for (int unsigned i = 0; i < NUM_DR; i++) begin
         if (sel_i == SEL_W'(i)) begin
            exp_len_c = DR_LEN[i*CNT_W +: CNT_W];
         end
      end
   end

   // Capture restarts the count; shifting saturates instead of wrapping.
   always_comb begin
      cnt_d     = cnt_q;
      len_err_d = len_err_q;
      if (capture_i) begin
         cnt_d = '0;
      end else if (shift_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (tlr_i) begin
         len_err_d = 1'b0;
      end else if (update_i) begin
         len_err_d = (cnt_q != exp_len_c);
      end
   end

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         cnt_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         len_err_q <= len_err_d;
      end
   end

   assign scan_len_o = cnt_q;
   assign len_err_o  = len_err_q;

endmodule

// File: rtl/etap_dr_router.sv
// EJTAG TAP data-register router: channel select, one-hot strobe fan-out, retimed TDO.
// Scan-length counting and len_err are built only when ETAP_DR_LEN_CHECK_EN is defined.
module etap_dr_router
   import etap_pkg::*;
#(
   parameter int unsigned             NUM_DR    = 8,
   parameter int unsigned             SEL_W     = 4,
   parameter int unsigned             CNT_W     = 8,
   parameter int unsigned             IDCODE_CH = CH_IDCODE,
   parameter int unsigned             BYPASS_CH = CH_BYPASS,
   parameter logic [NUM_DR*CNT_W-1:0] DR_LEN    =
      (NUM_DR*CNT_W)'(dr_len_default(NUM_DR, CNT_W, BYPASS_CH))
) (
   input  logic              tck,
   input  logic              trst_n,
   etap_dr_router_if.slave   dr
);

   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              tdo_q, tdo_d;
   logic              oe_q;
   logic [NUM_DR-1:0] ch_hit_c;
   logic              tdo_bit_c;
   logic              dr_active_c;

   for (genvar g = 0; g < NUM_DR; g++) begin : g_ch_hit
      assign ch_hit_c[g] = (sel_q == SEL_W'(g));
   end

   assign dr.capture_en_out = {NUM_DR{dr.capture_dr}} & ch_hit_c;
   assign dr.shift_en_out   = {NUM_DR{dr.shift_dr}}   & ch_hit_c;
   assign dr.update_en_out  = {NUM_DR{dr.update_dr}}  & ch_hit_c;
   assign tdo_bit_c         = |(dr.s_data_in & ch_hit_c);
   assign dr_active_c       = dr.capture_dr | dr.shift_dr | dr.update_dr;

   // An IR update overlapping any DR strobe is illegal and leaves the selection alone.
   always_comb begin
      sel_d = sel_q;
      tdo_d = tdo_q;
      if (dr.test_logic_reset) begin
         sel_d = SEL_W'(IDCODE_CH);
      end else if (dr.update_ir && !dr_active_c) begin
         sel_d = (32'(dr.ir_sel) < NUM_DR) ? dr.ir_sel : SEL_W'(BYPASS_CH);
      end
      if (dr.shift_dr) begin
         tdo_d = tdo_bit_c;
      end
   end

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         sel_q <= SEL_W'(IDCODE_CH);
         tdo_q <= 1'b0;
         oe_q  <= 1'b0;
      end else begin
         sel_q <= sel_d;
         tdo_q <= tdo_d;
         oe_q  <= dr.shift_dr;
      end
   end

   assign dr.sel_cur    = sel_q;
   assign dr.s_data_out = tdo_q;
   assign dr.s_data_oe  = oe_q;

`ifdef ETAP_DR_LEN_CHECK_EN
   etap_scan_counter #(
      .NUM_DR (NUM_DR),
      .SEL_W  (SEL_W),
      .CNT_W  (CNT_W),
      .DR_LEN (DR_LEN)
   ) u_scan_counter (
      .tck        (tck),
      .trst_n     (trst_n),
      .tlr_i      (dr.test_logic_reset),
      .capture_i  (dr.capture_dr),
      .shift_i    (dr.shift_dr),
      .update_i   (dr.update_dr),
      .sel_i      (sel_q),
      .scan_len_o (dr.scan_len),
      .len_err_o  (dr.len_err)
   );
`else
   // The length table has no consumer without the checker.
   logic unused_dr_len;
   assign unused_dr_len = ^DR_LEN;
   assign dr.scan_len   = '0;
   assign dr.len_err    = 1'b0;
`endif

endmodule

// File: tb/tb_etap_dr_router.sv
// Self-checking bench for etap_dr_router: select table, TDO scoreboard, length/reset sequences.
module tb_etap_dr_router;

   localparam int unsigned NUM_DR = 8;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned NVEC   = 16;
`ifdef ETAP_DR_LEN_CHECK_EN
   localparam bit LEN_EN = 1'b1;
`else
   localparam bit LEN_EN = 1'b0;
`endif

   logic tck = 1'b0;
   logic trst_n;
   always #5 tck = ~tck;

   etap_dr_router_if #(.NUM_DR(NUM_DR), .SEL_W(SEL_W), .CNT_W(CNT_W)) dr_if ();

   etap_dr_router #(.NUM_DR(NUM_DR), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .tck    (tck),
      .trst_n (trst_n),
      .dr     (dr_if)
   );

   typedef struct {
      logic [3:0] ir;
      bit         uir, cap, sh, upd, tlr;
      logic [3:0] exp_sel;
      logic [7:0] exp_cap, exp_sh, exp_upd;
   } vec_t;

   vec_t        vt [NVEC];
   bit          exp_q [$];
   int          errors = 0;
   int          checks = 0;
   int unsigned sel_m  = 0;
   bit          tdo_m  = 1'b0;
   bit          err_m  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge tck);
      #1;
   endtask

   task automatic idle();
      dr_if.test_logic_reset = 1'b0;
      dr_if.ir_sel           = '0;
      dr_if.update_ir        = 1'b0;
      dr_if.capture_dr       = 1'b0;
      dr_if.shift_dr         = 1'b0;
      dr_if.update_dr        = 1'b0;
      dr_if.s_data_in        = '0;
   endtask

   function automatic int unsigned exp_len(input int unsigned ch);
      return (ch == 7) ? 1 : 32;
   endfunction

   task automatic select(input int unsigned code);
      dr_if.ir_sel    = SEL_W'(code);
      dr_if.update_ir = 1'b1;
      step();
      dr_if.update_ir = 1'b0;
      sel_m = (code < NUM_DR) ? code : 7;
      check($sformatf("select %0d sel_cur", code), 32'(dr_if.sel_cur), sel_m);
   endtask

   // One shift cycle: drive random channel data, score the selected bit one tck later.
   task automatic shift_one(input string tag, input int idx, input bit toggle);
      logic [NUM_DR-1:0] din;
      din = NUM_DR'($urandom);
      if (toggle) begin
         din = (din & ~(NUM_DR'(1) << sel_m)) | (NUM_DR'(idx & 1) << sel_m);
      end
      dr_if.s_data_in = din;
      dr_if.shift_dr  = 1'b1;
      exp_q.push_back(1'(din >> sel_m));
      step();
      if (exp_q.size() == 0) begin
         check({tag, " scoreboard empty"}, 32'd1, 32'd0);
      end else begin
         tdo_m = exp_q.pop_front();
         check($sformatf("%s tdo bit%0d", tag, idx), 32'(dr_if.s_data_out), 32'(tdo_m));
         check($sformatf("%s oe bit%0d", tag, idx), 32'(dr_if.s_data_oe), 32'd1);
      end
   endtask

   task automatic scan(input string tag, input int n, input bit toggle);
      int unsigned want;
      dr_if.capture_dr = 1'b1;
      #1;
      check({tag, " cap_en"}, 32'(dr_if.capture_en_out), 32'd1 << sel_m);
      step();
      dr_if.capture_dr = 1'b0;
      check({tag, " oe after capture"}, 32'(dr_if.s_data_oe), 32'd0);
      check({tag, " scan_len after capture"}, 32'(dr_if.scan_len), 32'd0);
      check({tag, " len_err held over capture"}, 32'(dr_if.len_err), 32'(LEN_EN & err_m));
      for (int i = 0; i < n; i++) shift_one(tag, i, toggle);
      dr_if.shift_dr  = 1'b0;
      dr_if.s_data_in = NUM_DR'($urandom);
      dr_if.update_dr = 1'b1;
      #1;
      check({tag, " upd_en"}, 32'(dr_if.update_en_out), 32'd1 << sel_m);
      step();
      dr_if.update_dr = 1'b0;
      want  = (n > 255) ? 255 : n;
      err_m = (want != exp_len(sel_m));
      check({tag, " oe after shift"}, 32'(dr_if.s_data_oe), 32'd0);
      check({tag, " tdo holds"}, 32'(dr_if.s_data_out), 32'(tdo_m));
      check({tag, " scan_len"}, 32'(dr_if.scan_len), LEN_EN ? want : 32'd0);
      check({tag, " len_err"}, 32'(dr_if.len_err), 32'(LEN_EN & err_m));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //              ir    uir   cap   sh    upd   tlr   sel    cap_en  sh_en   upd_en
      vt[0]  = '{4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 8'h00, 8'h00, 8'h00};
      vt[1]  = '{4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00, 8'h08, 8'h00};
      vt[2]  = '{4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 8'h08, 8'h00, 8'h00};
      vt[3]  = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 8'h00, 8'h08};
      vt[4]  = '{4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 8'h00, 8'h00, 8'h00};
      vt[5]  = '{4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 8'h00, 8'h80, 8'h00};
      vt[6]  = '{4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 8'h80, 8'h00, 8'h00};
      vt[7]  = '{4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 8'h00, 8'h00, 8'h00};
      vt[8]  = '{4'd2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00, 8'h08, 8'h00};
      vt[9]  = '{4'd2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 8'h00, 8'h08};
      vt[10] = '{4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00, 8'h00, 8'h00};
      vt[11] = '{4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 8'h00, 8'h00, 8'h00};
      vt[12] = '{4'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 8'h00, 8'h00, 8'h00};
      vt[13] = '{4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 8'h00, 8'h00, 8'h00};
      vt[14] = '{4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'h00, 8'h00, 8'h00};
      vt[15] = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00, 8'h00, 8'h00};

      idle();
      trst_n = 1'b0;
      repeat (3) step();
      trst_n = 1'b1;
      step();
      check("reset sel_cur", 32'(dr_if.sel_cur), 32'd0);
      check("reset cap_en", 32'(dr_if.capture_en_out), 32'd0);
      check("reset shift_en", 32'(dr_if.shift_en_out), 32'd0);
      check("reset upd_en", 32'(dr_if.update_en_out), 32'd0);
      check("reset tdo", 32'(dr_if.s_data_out), 32'd0);
      check("reset oe", 32'(dr_if.s_data_oe), 32'd0);
      check("reset scan_len", 32'(dr_if.scan_len), 32'd0);
      check("reset len_err", 32'(dr_if.len_err), 32'd0);

      scan("idcode", 32, 1'b1);

      for (int r = 0; r < int'(NVEC); r++) begin
         dr_if.ir_sel           = vt[r].ir;
         dr_if.update_ir        = vt[r].uir;
         dr_if.capture_dr       = vt[r].cap;
         dr_if.shift_dr         = vt[r].sh;
         dr_if.update_dr        = vt[r].upd;
         dr_if.test_logic_reset = vt[r].tlr;
         dr_if.s_data_in        = '0;
         #1;
         check($sformatf("vec%0d cap_en", r), 32'(dr_if.capture_en_out), 32'(vt[r].exp_cap));
         check($sformatf("vec%0d shift_en", r), 32'(dr_if.shift_en_out), 32'(vt[r].exp_sh));
         check($sformatf("vec%0d upd_en", r), 32'(dr_if.update_en_out), 32'(vt[r].exp_upd));
         step();
         check($sformatf("vec%0d sel_cur", r), 32'(dr_if.sel_cur), 32'(vt[r].exp_sel));
      end
      idle();
      sel_m = 0;
      tdo_m = 1'b0;
      err_m = 1'b0;

      select(4);
      scan("ctl31", 31, 1'b0);
      scan("ctl32", 32, 1'b0);
      select(12);
      scan("bypass1", 1, 1'b0);
      select(4);
      scan("sat300", 300, 1'b0);

      // Mid-scan asynchronous reset with len_err set and shift_dr still high.
      select(3);
      dr_if.capture_dr = 1'b1;
      step();
      dr_if.capture_dr = 1'b0;
      for (int i = 0; i < 10; i++) shift_one("midscan", i, 1'b0);
      #2;
      trst_n = 1'b0;
      #1;
      check("trst sel_cur", 32'(dr_if.sel_cur), 32'd0);
      check("trst scan_len", 32'(dr_if.scan_len), 32'd0);
      check("trst oe", 32'(dr_if.s_data_oe), 32'd0);
      check("trst tdo", 32'(dr_if.s_data_out), 32'd0);
      check("trst len_err", 32'(dr_if.len_err), 32'd0);
      check("trst shift_en follows strobe", 32'(dr_if.shift_en_out), 32'h01);
      idle();
      step();
      trst_n = 1'b1;
      step();
      sel_m = 0;
      tdo_m = 1'b0;
      err_m = 1'b0;
      scan("recover", 32, 1'b1);

      // test_logic_reset wins over update_ir and clears len_err.
      select(2);
      scan("addr5", 5, 1'b0);
      dr_if.test_logic_reset = 1'b1;
      dr_if.update_ir        = 1'b1;
      dr_if.ir_sel           = 4'd5;
      step();
      idle();
      sel_m = 0;
      err_m = 1'b0;
      check("tlr sel_cur", 32'(dr_if.sel_cur), 32'd0);
      check("tlr len_err", 32'(dr_if.len_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/etap_dr_router.md
# etap_dr_router

Parametrised, registered successor to the EJTAG TAP data-register multiplexer. Holds the active DR channel, latched from the IR decode on update_ir. Fans the TAP controller's capture/shift/update strobes out as one-hot per-channel enables. Returns the selected channel's serial bit as a retimed TDO with output enable, and counts shifted bits per scan so length mismatches can be flagged. Sits between the TAP FSM/IR decoder and the bank of EJTAG data registers.

## Interface
- NUM_DR, 8, number of DR channels (≥2)
- SEL_W, 4, width of IR select code
- CNT_W, 8, width of scan-length counter
- IDCODE_CH, 0, channel selected after reset / test_logic_reset
- BYPASS_CH, 7, channel used for any select code ≥ NUM_DR
- DR_LEN, {NUM_DR{8'd32}} with BYPASS_CH slot = 1, packed NUM_DR×CNT_W expected length per channel

Ports:
- tck  in  1  TAP clock, all state on rising edge
- trst_n  in  1  asynchronous active-low reset
- test_logic_reset  in  1  TAP in Test-Logic-Reset, synchronous
- ir_sel  in  SEL_W  decoded instruction select
- update_ir  in  1  Update-IR state strobe
- capture_dr / shift_dr / update_dr  in  1 each  TAP DR state strobes, one tck per state
- s_data_in  in  NUM_DR  serial output of each DR
- capture_en_out / shift_en_out / update_en_out  out  NUM_DR each  one-hot per-channel enables
- s_data_out  out  1  registered TDO bit
- s_data_oe  out  1  registered TDO enable
- sel_cur  out  SEL_W  active channel index
- scan_len  out  CNT_W  bits shifted in last/current scan
- len_err  out  1  last completed scan length ≠ DR_LEN[sel_cur]

## Operation
- Select register sel_q:
  - Priority: trst_n → test_logic_reset → update_ir.
  - Reset and test_logic_reset load IDCODE_CH.
  - update_ir loads ir_sel when ir_sel < NUM_DR, else BYPASS_CH.
  - update_ir is ignored when any of capture_dr/shift_dr/update_dr is also high (illegal overlap); sel_q holds.
- Enables are combinational from sel_q: X_en_out[i] = X_dr & (sel_q == i); all zero when X_dr is low.
- TDO: on each tck, s_data_out <= shift_dr ? s_data_in[sel_q] : s_data_out; s_data_oe <= shift_dr.
- Counter:
  - capture_dr clears it to 0.
  - shift_dr increments it, saturating at 2^CNT_W−1 (no wrap).
  - It holds otherwise. scan_len = counter.
- On update_dr, len_err <= (counter ≠ DR_LEN[sel_q]). Held until the next update_dr, test_logic_reset (clears) or reset.
- Reset values: sel_q = IDCODE_CH, s_data_out = 0, s_data_oe = 0, scan_len = 0, len_err = 0.

## Timing
- sel_cur changes one tck after the update_ir edge. Enables follow in the same cycle (zero latency from sel_q).
- TDO latency: one tck from shift_dr/s_data_in to s_data_out.
- s_data_oe drops one tck after shift_dr falls. s_data_out holds its last shifted bit.
- A capture_dr directly following update_dr in the same scan pair starts a new count; len_err still reflects the prior update_dr.
- Asserting trst_n low mid-scan immediately forces all registers to their reset values. Enables go to 0 only via the strobes.

## Configuration
- ETAP_DR_LEN_CHECK_EN defined: counter, DR_LEN compare and len_err are present as above.
- Undefined: no counter or compare logic. scan_len and len_err are tied to 0. The DR_LEN parameter is unused.

## Structure
- Shared package etap_pkg holds the channel index constants (IDCODE, IMPCODE, ADDRESS, DATA, CONTROL, EJTAGBOOT, SAMPLE_PRELOAD, BYPASS) and default DR lengths, replacing the current select macros.
- One sub-module: etap_scan_counter (clear/increment/saturate, length compare, len_err register), instantiated only under ETAP_DR_LEN_CHECK_EN.

## Test plan
- Reset → sel_cur=0, all enables 0, s_data_out=0, s_data_oe=0, len_err=0. A 32-bit IDCODE scan with s_data_in[0] toggling reproduces the pattern on s_data_out one tck late.
- Select routing:
  - ir_sel=3 + update_ir → sel_cur=3 next tck.
  - shift_dr pulses only shift_en_out[3].
  - ir_sel=12 → sel_cur=7 (BYPASS).
- update_ir together with shift_dr, ir_sel=2, current sel=3 → sel_cur stays 3. Then test_logic_reset with update_ir → sel_cur=0.
- Length check with sel=4: capture, 31 shifts, update → scan_len=31, len_err=1. Next scan of 32 shifts → len_err=0. BYPASS scan of 1 shift → len_err=0.
- Saturation: 300 shifts with CNT_W=8 → scan_len=255, len_err=1.
- Mid-scan reset: trst_n low after 10 shifts → sel_cur=0, scan_len=0, s_data_oe=0 asynchronously. Recovery scan behaves normally.
